// File: rtl/mode_arbiter_pkg.sv
// Shared mode codes, note limits and FSM state type for the mode arbiter.
package mode_arbiter_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_FREE  = 2'd1;
    localparam logic [1:0] MODE_AUTO  = 2'd2;
    localparam logic [1:0] MODE_LEARN = 2'd3;

    localparam logic [3:0] NOTE_SILENCE = 4'd0;
    localparam logic [3:0] NOTE_MAX     = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_FREE,
        ST_AUTO,
        ST_LEARN
    } state_t;

    // Mode reached by one "next" press: IDLE->FREE->AUTO->LEARN->FREE.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return (m == MODE_LEARN) ? MODE_FREE : m + 2'd1;
    endfunction

    // Out-of-range notes are played as silence.
    function automatic logic [3:0] clip_note(input logic [3:0] n);
        return (n > NOTE_MAX) ? NOTE_SILENCE : n;
    endfunction

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            ST_FREE:  return MODE_FREE;
            ST_AUTO:  return MODE_AUTO;
            ST_LEARN: return MODE_LEARN;
            default:  return MODE_IDLE;
        endcase
    endfunction

    function automatic state_t state_of(input logic [1:0] m);
        case (m)
            MODE_FREE:  return ST_FREE;
            MODE_AUTO:  return ST_AUTO;
            MODE_LEARN: return ST_LEARN;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mode_arbiter_btn_debounce.sv
// Button front end: 2-FF synchroniser, debouncer and one-cycle press pulse.
// After reset the debouncer stays disarmed until it has seen the button
// released for DEBOUNCE_CYC samples, so a button held through reset never
// produces a press.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1, sync2;
    logic          level, armed;
    logic [CW-1:0] cnt;
    logic          want, hit;

    // Value the counter is waiting for: the opposite of the debounced level,
    // or "released" while still disarmed.
    assign want = armed & ~level;
    assign hit  = (sync2 == want) && (cnt == CNT_LAST);

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive samples at the wanted value; commit on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            if (sync2 != want || cnt == CNT_LAST) cnt <= '0;
            else                                  cnt <= cnt + CW'(1);
            if (hit) begin
                if (armed) level <= sync2;
                else       armed <= 1'b1;
            end
            press <= hit & armed & want;
        end
    end

endmodule

// File: rtl/mode_arbiter.sv
// Mode arbiter: grants one of three players, inserts a muted gap on every
// handover and drives the buzzer note / LED pattern of the granted player.
module mode_arbiter
    import mode_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int GAP_CYC      = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_stop,
    input  logic [3:0] free_note,
    input  logic [3:0] auto_note,
    input  logic [3:0] learn_note,
    input  logic [6:0] free_led,
    input  logic [6:0] auto_led,
    input  logic [6:0] learn_led,
    input  logic       auto_done,
    output logic       free_en,
    output logic       auto_en,
    output logic       learn_en,
    output logic [3:0] note_to_play,
    output logic [6:0] led_out,
    output logic [1:0] mode_out,
    output logic       muting
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    logic          next_p, stop_p;
    state_t        state, state_nx;
    logic [1:0]    target, target_nx;
    logic [GW-1:0] gap_cnt, gap_nx;

    logic [2:0]    en_nx;
    logic [3:0]    note_nx;
    logic [6:0]    led_nx;
    logic [1:0]    mode_nx;
    logic          mute_nx;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
        .clk(clk), .rst_n(rst_n), .btn(btn_next), .press(next_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stop (
        .clk(clk), .rst_n(rst_n), .btn(btn_stop), .press(stop_p)
    );

    // State, gap target and gap counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            target  <= MODE_IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            target  <= target_nx;
            gap_cnt <= gap_nx;
        end
    end

    // Next state: stop beats song end beats next beats gap countdown.
    // A next press during the gap advances from the pending target.
    always_comb begin
        state_nx  = state;
        target_nx = target;
        gap_nx    = gap_cnt;
        if (stop_p) begin
            state_nx = ST_IDLE;
        end else if (state == ST_AUTO && auto_done) begin
            state_nx = ST_IDLE;
        end else if (next_p) begin
            target_nx = next_mode((state == ST_GAP) ? target : mode_of(state));
            state_nx  = ST_GAP;
            gap_nx    = GAP_LAST;
        end else if (state == ST_GAP) begin
            if (gap_cnt == '0) state_nx = state_of(target);
            else               gap_nx   = gap_cnt - GW'(1);
        end
    end

    // Output mux keyed on the upcoming state so the registered outputs
    // change in the same cycle as the state register.
    always_comb begin
        en_nx   = 3'b000;
        note_nx = NOTE_SILENCE;
        led_nx  = '0;
        mode_nx = MODE_IDLE;
        mute_nx = 1'b0;
        case (state_nx)
            ST_GAP: begin
                mute_nx = 1'b1;
                mode_nx = target_nx;
            end
            ST_FREE: begin
                en_nx   = 3'b001;
                note_nx = clip_note(free_note);
                led_nx  = free_led;
                mode_nx = MODE_FREE;
            end
            ST_AUTO: begin
                en_nx   = 3'b010;
                note_nx = clip_note(auto_note);
                led_nx  = auto_led;
                mode_nx = MODE_AUTO;
            end
            ST_LEARN: begin
                en_nx   = 3'b100;
                note_nx = clip_note(learn_note);
                led_nx  = learn_led;
                mode_nx = MODE_LEARN;
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {learn_en, auto_en, free_en} <= 3'b000;
            note_to_play <= NOTE_SILENCE;
            led_out      <= '0;
            mode_out     <= MODE_IDLE;
            muting       <= 1'b0;
        end else begin
            {learn_en, auto_en, free_en} <= en_nx;
            note_to_play <= note_nx;
            led_out      <= led_nx;
            mode_out     <= mode_nx;
            muting       <= mute_nx;
        end
    end

endmodule
